// File: rtl/systolic_pkg.sv
// Shared types and default widths for the systolic matrix-multiply array.
package systolic_pkg;

  localparam int DW_DEF   = 8;
  localparam int ACCW_DEF = 24;
  localparam int OW_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: multiply-accumulate plus 1-cycle forwarding of a (east) and b (south).
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic [DW-1:0]   a_o,
  output logic [DW-1:0]   b_o,
  output logic [ACCW-1:0] acc_o
);

  logic [DW-1:0]   a_q, b_q;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] prod;

  // clr_i restarts the sum but still folds in this cycle's product (first beat at PE(0,0)).
  assign prod  = a_i * b_i;
  assign acc_d = (clr_i ? '0 : acc_q) + ACCW'(prod);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_nxn.sv
// N x N output-stationary systolic array computing C = A*B over K streamed beats.
// Build option: define SYSTOLIC_SAT_EN to saturate result elements instead of truncating.
module systolic_nxn
  import systolic_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int OW   = OW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [N*DW-1:0]      a_col,
  input  logic [N*DW-1:0]      b_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*OW-1:0]      out_row,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(3 * N);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(3 * N - 3);
`ifdef SYSTOLIC_SAT_EN
  localparam logic [ACCW-1:0] OMAX = ACCW'((64'd1 << OW) - 64'd1);
`endif

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic          accept, clr;

  logic [DW-1:0]   a_in [N];
  logic [DW-1:0]   b_in [N];
  logic [DW-1:0]   a_edge [N];
  logic [DW-1:0]   b_edge [N];
  logic [DW-1:0]   a_w [N][N];
  logic [DW-1:0]   b_w [N][N];
  logic [ACCW-1:0] acc_w [N][N];

  function automatic logic [OW-1:0] fmt_out(input logic [ACCW-1:0] v);
`ifdef SYSTOLIC_SAT_EN
    return (v > OMAX) ? OW'(OMAX) : OW'(v);
`else
    return OW'(v);
`endif
  endfunction

  assign accept = in_valid && in_ready;
  assign clr    = accept && (state_q == IDLE);

  // Skew stage: row/column i delayed i cycles; idle cycles feed zeros.
  for (genvar i = 0; i < N; i++) begin : g_skew
    assign a_in[i] = accept ? a_col[i*DW +: DW] : '0;
    assign b_in[i] = accept ? b_row[i*DW +: DW] : '0;
    if (i == 0) begin : g_pass
      assign a_edge[i] = a_in[i];
      assign b_edge[i] = b_in[i];
    end else begin : g_dly
      logic [DW-1:0] as_q [i];
      logic [DW-1:0] bs_q [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < i; k++) begin
            as_q[k] <= '0;
            bs_q[k] <= '0;
          end
        end else begin
          as_q[0] <= a_in[i];
          bs_q[0] <= b_in[i];
          for (int k = 1; k < i; k++) begin
            as_q[k] <= as_q[k-1];
            bs_q[k] <= bs_q[k-1];
          end
        end
      end
      assign a_edge[i] = as_q[i-1];
      assign b_edge[i] = bs_q[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_src, b_src;
      if (j == 0) begin : g_a_edge
        assign a_src = a_edge[i];
      end else begin : g_a_int
        assign a_src = a_w[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_src = b_edge[j];
      end else begin : g_b_int
        assign b_src = b_w[i-1][j];
      end
      systolic_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .a_i   (a_src),
        .b_i   (b_src),
        .a_o   (a_w[i][j]),
        .b_o   (b_w[i][j]),
        .acc_o (acc_w[i][j])
      );
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= in_last ? FLUSH : LOAD;
          cnt_q   <= FLUSH_LAST;
        end
        LOAD: if (accept && in_last) begin
          state_q <= FLUSH;
          cnt_q   <= FLUSH_LAST;
        end
        FLUSH: if (cnt_q == '0) begin
          state_q <= DRAIN;
          idx_q   <= '0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        DRAIN: if (out_ready) begin
          if (idx_q == IW'(N - 1)) begin
            state_q <= IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accumulators are frozen in DRAIN (only zeros flow), so the row mux holds steady under stall.
  always_comb begin
    out_row = '0;
    if (state_q == DRAIN) begin
      for (int j = 0; j < N; j++) begin
        out_row[j*OW +: OW] = fmt_out(acc_w[idx_q][j]);
      end
    end
  end

  assign in_ready  = rst && ((state_q == IDLE) || (state_q == LOAD));
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_systolic_nxn.sv
// Directed bench for systolic_nxn: N=2 and N=3 instances sharing clock and reset.
module tb_systolic_nxn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv2, il2, or2;
  logic [15:0] a2, b2;
  logic        ir2, ov2, bz2;
  logic [15:0] row2;
  logic [0:0]  idx2;

  logic        iv3, il3, or3;
  logic [23:0] a3, b3;
  logic        ir3, ov3, bz3;
  logic [23:0] row3;
  logic [1:0]  idx3;

  int n_chk  = 0;
  int n_fail = 0;

  systolic_nxn #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_last(il2),
    .a_col(a2), .b_row(b2), .out_valid(ov2), .out_ready(or2),
    .out_row(row2), .out_idx(idx2), .busy(bz2)
  );

  systolic_nxn #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_last(il3),
    .a_col(a3), .b_row(b3), .out_valid(ov3), .out_ready(or3),
    .out_row(row3), .out_idx(idx3), .busy(bz3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic beat2(input logic [15:0] a, input logic [15:0] b, input logic last);
    @(negedge clk);
    chk("in_ready2", 32'(ir2), 32'd1);
    iv2 = 1'b1; a2 = a; b2 = b; il2 = last;
    @(posedge clk);
    #1 iv2 = 1'b0; il2 = 1'b0; a2 = '0; b2 = '0;
  endtask

  task automatic beat3(input logic [23:0] a, input logic [23:0] b, input logic last);
    @(negedge clk);
    chk("in_ready3", 32'(ir3), 32'd1);
    iv3 = 1'b1; a3 = a; b3 = b; il3 = last;
    @(posedge clk);
    #1 iv3 = 1'b0; il3 = 1'b0; a3 = '0; b3 = '0;
  endtask

  // A=[[1,2],[3,4]] as columns, B=[[5,6],[7,8]] as rows.
  task automatic case1_beats(input int gap);
    beat2(16'h0301, 16'h0605, 1'b0);
    repeat (gap) @(negedge clk);
    beat2(16'h0402, 16'h0807, 1'b1);
  endtask

  task automatic drain2(input string tag, input logic [15:0] r0, input logic [15:0] r1,
                        input int stall);
    int c = 0;
    @(negedge clk);
    while (ov2 !== 1'b1 && c < 80) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_vld0"}, 32'(ov2), 32'd1);
    chk({tag, "_idx0"}, 32'(idx2), 32'd0);
    chk({tag, "_row0"}, 32'(row2), 32'(r0));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_vld"}, 32'(ov2), 32'd1);
      chk({tag, "_stall_idx"}, 32'(idx2), 32'd0);
      chk({tag, "_stall_row"}, 32'(row2), 32'(r0));
    end
    or2 = 1'b1;
    @(posedge clk);
    #1 or2 = 1'b0;
    @(negedge clk);
    chk({tag, "_vld1"}, 32'(ov2), 32'd1);
    chk({tag, "_idx1"}, 32'(idx2), 32'd1);
    chk({tag, "_row1"}, 32'(row2), 32'(r1));
    or2 = 1'b1;
    @(posedge clk);
    #1 or2 = 1'b0;
    @(negedge clk);
    chk({tag, "_done_vld"}, 32'(ov2), 32'd0);
    chk({tag, "_done_busy"}, 32'(bz2), 32'd0);
    chk({tag, "_done_rdy"}, 32'(ir2), 32'd1);
  endtask

  task automatic drain3(input string tag, input logic [23:0] r0, input logic [23:0] r1,
                        input logic [23:0] r2);
    logic [23:0] exp_rows [3];
    int c = 0;
    exp_rows[0] = r0; exp_rows[1] = r1; exp_rows[2] = r2;
    @(negedge clk);
    while (ov3 !== 1'b1 && c < 80) begin
      @(negedge clk);
      c++;
    end
    for (int r = 0; r < 3; r++) begin
      if (r != 0) @(negedge clk);
      chk({tag, "_vld"}, 32'(ov3), 32'd1);
      chk({tag, "_idx"}, 32'(idx3), 32'(r));
      chk({tag, "_row"}, 32'(row3), 32'(exp_rows[r]));
      or3 = 1'b1;
      @(posedge clk);
      #1 or3 = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_done_vld"}, 32'(ov3), 32'd0);
    chk({tag, "_done_busy"}, 32'(bz3), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_sat;
    rst = 1'b1;
    iv2 = 1'b0; il2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0;
    iv3 = 1'b0; il3 = 1'b0; or3 = 1'b0; a3 = '0; b3 = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_rdy2", 32'(ir2), 32'd0);
    chk("rst_vld2", 32'(ov2), 32'd0);
    chk("rst_busy2", 32'(bz2), 32'd0);
    chk("rst_idx2", 32'(idx2), 32'd0);
    chk("rst_row2", 32'(row2), 32'd0);
    chk("rst_rdy3", 32'(ir3), 32'd0);
    chk("rst_busy3", 32'(bz3), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_rdy2", 32'(ir2), 32'd1);
    chk("idle_busy2", 32'(bz2), 32'd0);

    // Case 1: contiguous beats
    case1_beats(0);
    drain2("c1", 16'h1613, 16'h322B, 0);

    // Case 2: two idle cycles between beats
    case1_beats(2);
    drain2("c2", 16'h1613, 16'h322B, 0);

    // Case 3: identity times B, then a K=1 job
    beat3(24'h000001, 24'h030201, 1'b0);
    beat3(24'h000100, 24'h060504, 1'b0);
    beat3(24'h010000, 24'h090807, 1'b1);
    drain3("c3", 24'h030201, 24'h060504, 24'h090807);
    beat3(24'h020202, 24'h030303, 1'b1);
    drain3("c3k1", 24'h060606, 24'h060606, 24'h060606);

    // Case 4: 200*200 = 40000 overflows the 8-bit result
`ifdef SYSTOLIC_SAT_EN
    exp_sat = 16'hFFFF;
`else
    exp_sat = 16'h4040;
`endif
    beat2(16'hC8C8, 16'hC8C8, 1'b1);
    drain2("c4", exp_sat, exp_sat, 0);

    // Case 5: consumer stalls three cycles on row 0
    case1_beats(0);
    drain2("c5", 16'h1613, 16'h322B, 3);

    // Case 6: reset in the middle of FLUSH, then rerun
    case1_beats(0);
    @(negedge clk);
    chk("c6_flush_busy", 32'(bz2), 32'd1);
    chk("c6_flush_rdy", 32'(ir2), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("c6_rst_vld", 32'(ov2), 32'd0);
    chk("c6_rst_busy", 32'(bz2), 32'd0);
    chk("c6_rst_rdy", 32'(ir2), 32'd0);
    chk("c6_rst_row", 32'(row2), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    case1_beats(0);
    drain2("c6", 16'h1613, 16'h322B, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
